// File: rtl/hwag_ch_sched.sv
`default_nettype none
// ============================================================================
// Module  : hwag_ch_sched
// Brief   : Angle-window output scheduler with one round-robin shared window
//           comparator and revolution-boundary shadow commit.
// Revision: 1.0
// ============================================================================
module hwag_ch_sched #(
  parameter int CH  = 4,
  parameter int AW  = 24,
  parameter int CAW = $clog2(CH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic                  rev_strobe,
  input  logic [AW-1:0]         acnt,
  input  logic [CH-1:0]         ch_ena,
  input  logic                  cfg_we,
  input  logic [CAW-1:0]        cfg_addr,
  input  logic [AW-1:0]         cfg_data,
  output logic [CH-1:0]         ch_out,
  output logic [CH-1:0]         ch_rise,
  output logic [CH-1:0]         ch_fall,
  output logic [CH-1:0]         upd_pend,
  output logic [$clog2(CH)-1:0] scan_ptr
);

  localparam int SW = $clog2(CH);
  localparam logic [SW-1:0] c_last = SW'(CH - 1);
  localparam logic [SW-1:0] c_one  = SW'(1);

  logic [AW-1:0] r_sh_set  [CH];
  logic [AW-1:0] r_sh_rst  [CH];
  logic [AW-1:0] r_act_set [CH];
  logic [AW-1:0] r_act_rst [CH];

  logic [SW-1:0] w_wr_ch;
  logic [AW-1:0] w_s;
  logic [AW-1:0] w_r;
  logic          w_in;
  logic          w_next;

  assign w_wr_ch = cfg_addr[CAW-1:1];
  assign w_s     = r_act_set[scan_ptr];
  assign w_r     = r_act_rst[scan_ptr];

  // S>R describes a window that wraps through angle 0; S==R is never active.
  always_comb begin
    w_in = 1'b0;
    if (w_s < w_r) begin
      w_in = (acnt >= w_s) && (acnt < w_r);
    end else if (w_s > w_r) begin
      w_in = (acnt >= w_s) || (acnt < w_r);
    end
  end

  assign w_next = hwag_start & ch_ena[scan_ptr] & w_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_ptr <= '0;
      ch_out   <= '0;
      ch_rise  <= '0;
      ch_fall  <= '0;
      upd_pend <= '0;
      for (int i = 0; i < CH; i++) begin
        r_sh_set[i]  <= '0;
        r_sh_rst[i]  <= '0;
        r_act_set[i] <= '0;
        r_act_rst[i] <= '0;
      end
    end else begin
      scan_ptr <= (scan_ptr == c_last) ? '0 : scan_ptr + c_one;

      ch_rise            <= '0;
      ch_fall            <= '0;
      ch_out[scan_ptr]   <= w_next;
      ch_rise[scan_ptr]  <= w_next & ~ch_out[scan_ptr];
      ch_fall[scan_ptr]  <= ~w_next & ch_out[scan_ptr];

      // A channel written this cycle skips the commit so a half-updated
      // window can never become active.
      for (int i = 0; i < CH; i++) begin
        if (cfg_we && (w_wr_ch == SW'(i))) begin
          if (cfg_addr[0]) begin
            r_sh_rst[i] <= cfg_data;
          end else begin
            r_sh_set[i] <= cfg_data;
          end
          if (hwag_start) begin
            upd_pend[i] <= 1'b1;
          end else if (cfg_addr[0]) begin
            r_act_rst[i] <= cfg_data;
          end else begin
            r_act_set[i] <= cfg_data;
          end
        end else if (rev_strobe && hwag_start && upd_pend[i]) begin
          r_act_set[i] <= r_sh_set[i];
          r_act_rst[i] <= r_sh_rst[i];
          upd_pend[i]  <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwag_ch_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_hwag_ch_sched
// Brief   : Directed self-checking bench for hwag_ch_sched (CH=4).
// Revision: 1.0
// ============================================================================
module tb_hwag_ch_sched;

  localparam int CH  = 4;
  localparam int AW  = 24;
  localparam int CAW = 3;

  logic           clk        = 1'b0;
  logic           rst        = 1'b0;
  logic           hwag_start = 1'b0;
  logic           rev_strobe = 1'b0;
  logic [AW-1:0]  acnt       = '0;
  logic [CH-1:0]  ch_ena     = '0;
  logic           cfg_we     = 1'b0;
  logic [CAW-1:0] cfg_addr   = '0;
  logic [AW-1:0]  cfg_data   = '0;
  logic [CH-1:0]  ch_out;
  logic [CH-1:0]  ch_rise;
  logic [CH-1:0]  ch_fall;
  logic [CH-1:0]  upd_pend;
  logic [1:0]     scan_ptr;

  int         tests    = 0;
  int         fails    = 0;
  logic [1:0] exp_ptr  = 2'd0;
  logic [1:0] prev_ptr = 2'd0;

  always #5 clk = ~clk;

  hwag_ch_sched #(.CH(CH), .AW(AW), .CAW(CAW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .rev_strobe (rev_strobe),
    .acnt       (acnt),
    .ch_ena     (ch_ena),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .ch_out     (ch_out),
    .ch_rise    (ch_rise),
    .ch_fall    (ch_fall),
    .upd_pend   (upd_pend),
    .scan_ptr   (scan_ptr)
  );

  // prev_ptr is the channel evaluated on the edge just taken.
  task automatic tick();
    @(posedge clk);
    prev_ptr = exp_ptr;
    exp_ptr  = rst ? exp_ptr + 2'd1 : 2'd0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [CAW-1:0] a, input logic [AW-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) begin
      hwag_start = 1'($urandom);
      rev_strobe = 1'($urandom);
      acnt       = AW'($urandom);
      ch_ena     = CH'($urandom);
      cfg_we     = 1'($urandom);
      cfg_addr   = CAW'($urandom);
      cfg_data   = AW'($urandom);
      tick();
    end
    tests++; if (ch_out !== 4'h0) begin fails++; $display("FAIL reset_out: got %h expected 0", ch_out); end
    tests++; if (ch_rise !== 4'h0) begin fails++; $display("FAIL reset_rise: got %h expected 0", ch_rise); end
    tests++; if (ch_fall !== 4'h0) begin fails++; $display("FAIL reset_fall: got %h expected 0", ch_fall); end
    tests++; if (upd_pend !== 4'h0) begin fails++; $display("FAIL reset_pend: got %h expected 0", upd_pend); end
    tests++; if (scan_ptr !== 2'd0) begin fails++; $display("FAIL reset_ptr: got %0d expected 0", scan_ptr); end
    cfg_we = 1'b0; rev_strobe = 1'b0; acnt = '0;
    hwag_start = 1'b1; ch_ena = 4'hF; rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++; if (scan_ptr !== 2'(k)) begin fails++; $display("FAIL scan_seq: got %0d expected %0d", scan_ptr, k % 4); end
      tests++; if ({ch_out, ch_rise, ch_fall} !== 12'h0) begin fails++; $display("FAIL idle_outs: got %h expected 0", {ch_out, ch_rise, ch_fall}); end
    end
  endtask

  task automatic test_plain_window();
    int nrise = 0, nfall = 0;
    int rise_a = -1, fall_a = -1;
    int rise_slot = -1, fall_slot = -1;
    hwag_start = 1'b0;
    cfg_write(3'b010, 24'd10);
    cfg_write(3'b011, 24'd20);
    tests++; if (upd_pend !== 4'h0) begin fails++; $display("FAIL plain_pend: got %h expected 0", upd_pend); end
    hwag_start = 1'b1;
    for (int a = 0; a <= 30; a++) begin
      acnt = AW'(a);
      repeat (8) begin
        tick();
        if (ch_rise[1]) begin nrise++; rise_a = a; rise_slot = int'(prev_ptr); end
        if (ch_fall[1]) begin nfall++; fall_a = a; fall_slot = int'(prev_ptr); end
      end
      tests++;
      if (ch_out[1] !== ((a >= 10) && (a < 20))) begin
        fails++; $display("FAIL plain_out acnt=%0d: got %b expected %b", a, ch_out[1], (a >= 10) && (a < 20));
      end
    end
    tests++; if (nrise !== 1) begin fails++; $display("FAIL plain_nrise: got %0d expected 1", nrise); end
    tests++; if (rise_a !== 10) begin fails++; $display("FAIL plain_rise_acnt: got %0d expected 10", rise_a); end
    tests++; if (rise_slot !== 1) begin fails++; $display("FAIL plain_rise_slot: got %0d expected 1", rise_slot); end
    tests++; if (nfall !== 1) begin fails++; $display("FAIL plain_nfall: got %0d expected 1", nfall); end
    tests++; if (fall_a !== 20) begin fails++; $display("FAIL plain_fall_acnt: got %0d expected 20", fall_a); end
    tests++; if (fall_slot !== 1) begin fails++; $display("FAIL plain_fall_slot: got %0d expected 1", fall_slot); end
  endtask

  task automatic test_wrap_window();
    int a;
    hwag_start = 1'b0;
    repeat (4) tick();
    cfg_write(3'b100, 24'd350);
    cfg_write(3'b101, 24'd5);
    tests++; if (upd_pend !== 4'h0) begin fails++; $display("FAIL wrap_pend: got %h expected 0", upd_pend); end
    hwag_start = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      a = (i < 20) ? 340 + i : i - 20;
      acnt = AW'(a);
      repeat (8) tick();
      tests++;
      if (ch_out[2] !== ((a >= 350) || (a < 5))) begin
        fails++; $display("FAIL wrap_out acnt=%0d: got %b expected %b", a, ch_out[2], (a >= 350) || (a < 5));
      end
    end
  endtask

  task automatic test_shadow_commit();
    logic [AW-1:0] angs [4] = '{24'd200, 24'd99, 24'd100, 24'd199};
    logic          exps [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    acnt = 24'd150;
    repeat (8) tick();
    cfg_write(3'b000, 24'd100);
    cfg_write(3'b001, 24'd200);
    repeat (8) tick();
    tests++; if (upd_pend !== 4'b0001) begin fails++; $display("FAIL shadow_pend: got %h expected 1", upd_pend); end
    tests++; if (ch_out[0] !== 1'b0) begin fails++; $display("FAIL shadow_old_window: got %b expected 0", ch_out[0]); end
    rev_strobe = 1'b1; tick(); rev_strobe = 1'b0;
    tests++; if (upd_pend !== 4'h0) begin fails++; $display("FAIL commit_pend: got %h expected 0", upd_pend); end
    repeat (8) tick();
    tests++; if (ch_out[0] !== 1'b1) begin fails++; $display("FAIL commit_window: got %b expected 1", ch_out[0]); end
    for (int k = 0; k < 4; k++) begin
      acnt = angs[k];
      repeat (8) tick();
      tests++;
      if (ch_out[0] !== exps[k]) begin
        fails++; $display("FAIL commit_edge acnt=%0d: got %b expected %b", angs[k], ch_out[0], exps[k]);
      end
    end
    acnt = 24'd150;
    repeat (8) tick();
    cfg_write(3'b110, 24'd50);
    cfg_write(3'b111, 24'd250);
    tests++; if (upd_pend !== 4'b1000) begin fails++; $display("FAIL ch3_pend: got %h expected 8", upd_pend); end
    repeat (8) tick();
    tests++; if (ch_out[3] !== 1'b0) begin fails++; $display("FAIL ch3_old_window: got %b expected 0", ch_out[3]); end
    cfg_we = 1'b1; cfg_addr = 3'b000; cfg_data = 24'd160; rev_strobe = 1'b1;
    tick();
    cfg_we = 1'b0; rev_strobe = 1'b0;
    tests++; if (upd_pend !== 4'b0001) begin fails++; $display("FAIL same_cycle_pend: got %h expected 1", upd_pend); end
    repeat (8) tick();
    tests++; if (ch_out !== 4'b1001) begin fails++; $display("FAIL same_cycle_out: got %h expected 9", ch_out); end
    rev_strobe = 1'b1; tick(); rev_strobe = 1'b0;
    tests++; if (upd_pend !== 4'h0) begin fails++; $display("FAIL second_commit_pend: got %h expected 0", upd_pend); end
    repeat (8) tick();
    tests++; if (ch_out !== 4'b1000) begin fails++; $display("FAIL second_commit_out: got %h expected 8", ch_out); end
    acnt = 24'd170;
    repeat (8) tick();
    tests++; if (ch_out !== 4'b1001) begin fails++; $display("FAIL both_active: got %h expected 9", ch_out); end
  endtask

  task automatic test_enable_mask();
    int nfall3 = 0;
    ch_ena = 4'b0111;
    repeat (8) begin
      tick();
      if (ch_fall[3]) nfall3++;
    end
    tests++; if (ch_out !== 4'b0001) begin fails++; $display("FAIL ena_out: got %h expected 1", ch_out); end
    tests++; if (nfall3 !== 1) begin fails++; $display("FAIL ena_nfall: got %0d expected 1", nfall3); end
    ch_ena = 4'hF;
    repeat (8) tick();
    tests++; if (ch_out !== 4'b1001) begin fails++; $display("FAIL ena_restore: got %h expected 9", ch_out); end
  endtask

  task automatic test_stop();
    logic [3:0] mask;
    logic [3:0] exp_fall;
    mask = 4'b1001;
    hwag_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_fall = mask[prev_ptr] ? (4'b0001 << prev_ptr) : 4'b0000;
      mask[prev_ptr] = 1'b0;
      tests++; if (ch_fall !== exp_fall) begin fails++; $display("FAIL stop_fall slot=%0d: got %h expected %h", prev_ptr, ch_fall, exp_fall); end
      tests++; if (ch_out !== mask) begin fails++; $display("FAIL stop_out slot=%0d: got %h expected %h", prev_ptr, ch_out, mask); end
    end
  endtask

  task automatic test_reset_active();
    hwag_start = 1'b1;
    repeat (8) tick();
    tests++; if (ch_out !== 4'b1001) begin fails++; $display("FAIL restart_out: got %h expected 9", ch_out); end
    rst = 1'b0;
    tick();
    tests++; if (ch_out !== 4'h0) begin fails++; $display("FAIL rst_active_out: got %h expected 0", ch_out); end
    tests++; if (ch_fall !== 4'h0) begin fails++; $display("FAIL rst_active_fall: got %h expected 0", ch_fall); end
    tests++; if (upd_pend !== 4'h0) begin fails++; $display("FAIL rst_active_pend: got %h expected 0", upd_pend); end
    tests++; if (scan_ptr !== 2'd0) begin fails++; $display("FAIL rst_active_ptr: got %0d expected 0", scan_ptr); end
    rst = 1'b1;
    repeat (8) tick();
    tests++; if (ch_out !== 4'h0) begin fails++; $display("FAIL post_rst_window_cleared: got %h expected 0", ch_out); end
    tests++; if (scan_ptr !== exp_ptr) begin fails++; $display("FAIL post_rst_ptr: got %0d expected %0d", scan_ptr, exp_ptr); end
  endtask

  initial begin
    test_reset();
    test_plain_window();
    test_wrap_window();
    test_shadow_commit();
    test_enable_mask();
    test_stop();
    test_reset_active();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
